fw_rule_lookup: RTL and testbench
=================================

# fw_rule_lookup

Firewall rule-table lookup engine; sits directly upstream of the SRAM arbiter on its module read port (rd_0). For each header key from the packet path it scans a linear rule table in SRAM, one 64-bit word per rule, and returns the first matching rule's action. It is a read-only client; the table is written through the register interface.

## Interface
Parameters:
- SRAM_ADDR_WIDTH, 19, SRAM word address width.
- RULE_BASE, 0, word address of rule 0.
- NUM_RULES, 64, maximum rules scanned (1..256).
- VLD_TIMEOUT, 15, cycles allowed from rd_0_ack to rd_0_vld.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- lookup_req  in  1  key valid.
- lookup_key  in  56  {dst_ip[55:24], dst_port[23:8], proto[7:0]}.
- lookup_rdy  out  1  engine idle; key accepted on lookup_req && lookup_rdy.
- result_vld  out  1  one-cycle result strobe.
- result_hit  out  1  a rule matched.
- result_deny  out  1  action: 1 = drop, 0 = forward.
- result_idx  out  8  index of the matching rule.
- result_err  out  1  parity error or timeout occurred.
- rd_0_req  out  1  read request to arbiter.
- rd_0_addr  out  SRAM_ADDR_WIDTH  read word address.
- rd_0_ack  in  1  arbiter accepted the read.
- rd_0_vld  in  1  rd_0_data valid.
- rd_0_data  in  64  rule word.

## Operation
- Rule word: [63:32] ip, [31:16] port, [15:8] proto, [7] valid, [6] deny, [5:0] reserved.
- Rule match: valid=1, and each of the following holds:
  - ip==0 or ip==key ip;
  - port==0 or port==key port;
  - proto==0 or proto==key proto.
  - A zero field is a wildcard.
- FSM states: IDLE, ISSUE, ACK_CHK, WAIT_VLD, CHECK, DONE.
- IDLE:
  - lookup_rdy=1.
  - On accept: latch key, idx=0, go to ISSUE.
- ISSUE:
  - rd_0_req=1 for exactly one cycle.
  - rd_0_addr=RULE_BASE+idx, truncated to SRAM_ADDR_WIDTH.
  - Go to ACK_CHK.
- ACK_CHK:
  - rd_0_req=0.
  - If rd_0_ack: clear watchdog, go to WAIT_VLD.
  - Else (arbiter served a register or write access, or is in its post-reset clear): back to ISSUE. Retries are unbounded.
- WAIT_VLD:
  - On rd_0_vld: capture rd_0_data, go to CHECK.
  - If the watchdog reaches VLD_TIMEOUT first: err=1, go to DONE with hit=0.
- CHECK:
  - Data == 64'h0000_0000_DEAD_BEEF is the parity-error marker: err=1, DONE, hit=0.
  - Else if valid=0: end of table, DONE, hit=0.
  - Else if match: DONE, hit=1, deny=rule[6], idx=current.
  - Else if idx==NUM_RULES-1: DONE, hit=0.
  - Else idx+1, go to ISSUE.
- DONE:
  - result_vld=1 for one cycle, with the result fields.
  - Go to IDLE.
- On a miss, result_deny=1: default deny.
- Result fields hold their values until the next result_vld.
- rd_0_vld seen outside WAIT_VLD is ignored.

## Timing
- Reset values:
  - lookup_rdy=0 during reset, 1 in the first cycle after.
  - result_vld, result_hit, result_deny, result_err, rd_0_req = 0.
  - result_idx=0, rd_0_addr=0.
  - FSM in IDLE.
- Arbiter contract: rd_0_ack is asserted in the cycle after rd_0_req is sampled. rd_0_vld follows 3 cycles after rd_0_ack.
- Accept in cycle 0, uncontended, hit on rule 0:
  - ISSUE in cycle 1, ack in cycle 2, vld in cycle 5, CHECK in cycle 6.
  - result_vld in cycle 7.
- Each further rule scanned adds 6 cycles.
- Each lost arbitration adds 2 cycles.
- Worst case, uncontended: 1 + 6·NUM_RULES cycles.
- At most one read is outstanding.
- Reset mid-scan: abort at once, no result_vld. A late rd_0_vld after reset is ignored (FSM is in IDLE).
- lookup_req while busy: not accepted (lookup_rdy=0). The source must hold the key.

## Configuration
- FW_LOOKUP_STATS_EN defined:
  - Adds outputs stat_hits, stat_misses, stat_errs, each 32 bits.
  - Each increments on result_vld per outcome; an error counts only in stat_errs.
  - Saturate at 32'hFFFF_FFFF; reset to 0.
- Undefined: these ports and counters do not exist.

## Test plan
- Rule0 = {ip 0A000001, port 0050, proto 06, valid, deny}; key 0A000001/0050/06 → result_vld in cycle 7, hit=1, deny=1, idx=0.
- Rules 0–2 non-matching, rule 3 all-wildcard with valid=1, deny=0 → hit=1, deny=0, idx=3, result_vld in cycle 25.
- Rule 2 valid=0, key matches nothing before it → hit=0, deny=1, err=0, scan stops after 3 reads.
- Arbiter withholds ack for 3 ISSUE attempts → rd_0_req re-pulsed 4 times, one read only, result delayed by 6 cycles.
- rd_0_data=64'h00000000DEADBEEF on rule 0 → err=1, hit=0, deny=1; with FW_LOOKUP_STATS_EN, stat_errs=1.
- Ack given, rd_0_vld never arrives → result_vld with err=1 exactly VLD_TIMEOUT cycles after ack. Reset asserted in WAIT_VLD → no result, lookup_rdy=1 after reset.

Source files
------------

// File: rtl/fw_rule_lookup_if.sv
// rtl/fw_rule_lookup_if.sv - key/result and SRAM read-port bundle for fw_rule_lookup
// Optional stats signals exist only when FW_LOOKUP_STATS_EN is defined.
interface fw_rule_lookup_if #(
   parameter int SRAM_ADDR_WIDTH = 19
) ();
   logic                       lookup_req;
   logic [55:0]                lookup_key;
   logic                       lookup_rdy;
   logic                       result_vld;
   logic                       result_hit;
   logic                       result_deny;
   logic [7:0]                 result_idx;
   logic                       result_err;
   logic                       rd_0_req;
   logic [SRAM_ADDR_WIDTH-1:0] rd_0_addr;
   logic                       rd_0_ack;
   logic                       rd_0_vld;
   logic [63:0]                rd_0_data;
`ifdef FW_LOOKUP_STATS_EN
   logic [31:0]                stat_hits;
   logic [31:0]                stat_misses;
   logic [31:0]                stat_errs;
`endif

   // master: packet path plus arbiter side; slave: the lookup engine
   modport master (
      output lookup_req, lookup_key, rd_0_ack, rd_0_vld, rd_0_data,
      input  lookup_rdy, result_vld, result_hit, result_deny, result_idx, result_err,
      input  rd_0_req, rd_0_addr
`ifdef FW_LOOKUP_STATS_EN
      , input stat_hits, stat_misses, stat_errs
`endif
   );

   modport slave (
      input  lookup_req, lookup_key, rd_0_ack, rd_0_vld, rd_0_data,
      output lookup_rdy, result_vld, result_hit, result_deny, result_idx, result_err,
      output rd_0_req, rd_0_addr
`ifdef FW_LOOKUP_STATS_EN
      , output stat_hits, stat_misses, stat_errs
`endif
   );
endinterface

// File: rtl/fw_rule_lookup.sv
// rtl/fw_rule_lookup.sv - first-match firewall rule scan over SRAM read port rd_0
// Define FW_LOOKUP_STATS_EN to add saturating hit/miss/error counters.
module fw_rule_lookup #(
   parameter int SRAM_ADDR_WIDTH = 19,
   parameter int RULE_BASE       = 0,
   parameter int NUM_RULES       = 64,
   parameter int VLD_TIMEOUT     = 15
) (
   input logic             clk,
   input logic             reset,
   fw_rule_lookup_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_ACK_CHK, S_WAIT_VLD, S_CHECK, S_DONE
   } state_t;

   localparam int          WD_W        = $clog2(VLD_TIMEOUT + 1);
   localparam logic [63:0] PARITY_MARK = 64'h0000_0000_DEAD_BEEF;

   state_t                     r_state;
   logic [55:0]                r_key;
   logic [63:0]                r_data;
   logic [7:0]                 r_idx;
   logic [WD_W-1:0]            r_wd;
   logic                       r_rd_req;
   logic [SRAM_ADDR_WIDTH-1:0] r_rd_addr;
   logic                       r_res_vld;
   logic                       r_res_hit;
   logic                       r_res_deny;
   logic                       r_res_err;
   logic [7:0]                 r_res_idx;

   logic w_parity;
   logic w_valid;
   logic w_ip_ok;
   logic w_port_ok;
   logic w_proto_ok;
   logic w_match;
   logic w_last;

   function automatic logic [SRAM_ADDR_WIDTH-1:0] f_rule_addr(input logic [7:0] i);
      return SRAM_ADDR_WIDTH'(RULE_BASE + int'(i));
   endfunction

   // Zero-valued rule fields act as wildcards
   assign w_parity   = (r_data == PARITY_MARK);
   assign w_valid    = r_data[7];
   assign w_ip_ok    = (r_data[63:32] == 32'd0) || (r_data[63:32] == r_key[55:24]);
   assign w_port_ok  = (r_data[31:16] == 16'd0) || (r_data[31:16] == r_key[23:8]);
   assign w_proto_ok = (r_data[15:8]  == 8'd0)  || (r_data[15:8]  == r_key[7:0]);
   assign w_match    = !w_parity && w_valid && w_ip_ok && w_port_ok && w_proto_ok;
   assign w_last     = (r_idx == 8'(NUM_RULES - 1));

   assign bus.lookup_rdy  = (r_state == S_IDLE) && !reset;
   assign bus.rd_0_req    = r_rd_req;
   assign bus.rd_0_addr   = r_rd_addr;
   assign bus.result_vld  = r_res_vld;
   assign bus.result_hit  = r_res_hit;
   assign bus.result_deny = r_res_deny;
   assign bus.result_idx  = r_res_idx;
   assign bus.result_err  = r_res_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_key      <= '0;
         r_data     <= '0;
         r_idx      <= '0;
         r_wd       <= '0;
         r_rd_req   <= 1'b0;
         r_rd_addr  <= '0;
         r_res_vld  <= 1'b0;
         r_res_hit  <= 1'b0;
         r_res_deny <= 1'b0;
         r_res_err  <= 1'b0;
         r_res_idx  <= '0;
      end else begin
         r_rd_req  <= 1'b0;
         r_res_vld <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.lookup_req) begin
                  r_key     <= bus.lookup_key;
                  r_idx     <= '0;
                  r_rd_addr <= f_rule_addr(8'd0);
                  r_rd_req  <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: r_state <= S_ACK_CHK;
            S_ACK_CHK: begin
               if (bus.rd_0_ack) begin
                  r_wd    <= WD_W'(1);
                  r_state <= S_WAIT_VLD;
               end else begin
                  // Lost arbitration: re-pulse the same address
                  r_rd_req <= 1'b1;
                  r_state  <= S_ISSUE;
               end
            end
            S_WAIT_VLD: begin
               if (bus.rd_0_vld) begin
                  r_data  <= bus.rd_0_data;
                  r_state <= S_CHECK;
               end else if (r_wd == WD_W'(VLD_TIMEOUT - 1)) begin
                  r_res_vld  <= 1'b1;
                  r_res_hit  <= 1'b0;
                  r_res_deny <= 1'b1;
                  r_res_err  <= 1'b1;
                  r_res_idx  <= r_idx;
                  r_state    <= S_DONE;
               end else begin
                  r_wd <= r_wd + WD_W'(1);
               end
            end
            S_CHECK: begin
               if (w_parity || !w_valid || w_match || w_last) begin
                  r_res_vld  <= 1'b1;
                  r_res_hit  <= w_match;
                  r_res_deny <= w_match ? r_data[6] : 1'b1;
                  r_res_err  <= w_parity;
                  r_res_idx  <= r_idx;
                  r_state    <= S_DONE;
               end else begin
                  r_idx     <= r_idx + 8'd1;
                  r_rd_addr <= f_rule_addr(r_idx + 8'd1);
                  r_rd_req  <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef FW_LOOKUP_STATS_EN
   logic [31:0] r_stat_hits;
   logic [31:0] r_stat_misses;
   logic [31:0] r_stat_errs;

   // An errored lookup counts only as an error, never as a miss
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_hits   <= '0;
         r_stat_misses <= '0;
         r_stat_errs   <= '0;
      end else if (r_res_vld) begin
         if (r_res_err) begin
            if (r_stat_errs != 32'hFFFF_FFFF) r_stat_errs <= r_stat_errs + 32'd1;
         end else if (r_res_hit) begin
            if (r_stat_hits != 32'hFFFF_FFFF) r_stat_hits <= r_stat_hits + 32'd1;
         end else begin
            if (r_stat_misses != 32'hFFFF_FFFF) r_stat_misses <= r_stat_misses + 32'd1;
         end
      end
   end

   assign bus.stat_hits   = r_stat_hits;
   assign bus.stat_misses = r_stat_misses;
   assign bus.stat_errs   = r_stat_errs;
`endif
endmodule

// File: tb/tb_fw_rule_lookup.sv
// tb/tb_fw_rule_lookup.sv - randomized and directed bench for fw_rule_lookup with arbiter/SRAM model
// Expected results come from a first-match scan model over the bench's rule array.
module tb_fw_rule_lookup;
   localparam int NUM_RULES   = 64;
   localparam int VLD_TIMEOUT = 15;
   localparam logic [63:0] PAR = 64'h0000_0000_DEAD_BEEF;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fw_rule_lookup_if #(.SRAM_ADDR_WIDTH(19)) bus ();
   fw_rule_lookup #(.SRAM_ADDR_WIDTH(19), .RULE_BASE(0), .NUM_RULES(NUM_RULES), .VLD_TIMEOUT(VLD_TIMEOUT))
      dut (.clk(clk), .reset(reset), .bus(bus));

   logic [63:0] mem [0:255];
   int  vectors = 0, miscompares = 0;
   int  cyc = 0;
   int  n_req = 0, n_reads = 0, n_results = 0, res_cyc = 0;
   int  nack_left = 0;
   bit  drop_vld = 0, force_par = 0;
   logic obs_hit, obs_deny, obs_err;
   logic [7:0] obs_idx;
   int  acc, lat, dreq, dreads;
   bit  got;
   bit  exp_hit, exp_deny, exp_err;
   int  exp_idx, exp_reads, exp_lat;
   int  t_hits = 0, t_misses = 0, t_errs = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.result_vld === 1'b1) begin
         n_results <= n_results + 1;
         res_cyc   <= cyc;
         obs_hit   <= bus.result_hit;
         obs_deny  <= bus.result_deny;
         obs_err   <= bus.result_err;
         obs_idx   <= bus.result_idx;
      end
   end

   // Arbiter + SRAM: ack the cycle after a sampled request, data 3 cycles after ack
   initial begin
      logic [18:0] a;
      bus.rd_0_ack = 0; bus.rd_0_vld = 0; bus.rd_0_data = '0;
      forever begin
         @(negedge clk);
         if (bus.rd_0_req === 1'b1) begin
            n_req++;
            a = bus.rd_0_addr;
            if (nack_left > 0) nack_left--;
            else begin
               n_reads++;
               @(posedge clk); #1 bus.rd_0_ack = 1;
               @(posedge clk); #1 bus.rd_0_ack = 0;
               if (!drop_vld) begin
                  repeat (2) @(posedge clk);
                  #1 bus.rd_0_vld = 1; bus.rd_0_data = force_par ? PAR : mem[a[7:0]];
                  @(posedge clk); #1 bus.rd_0_vld = 0; bus.rd_0_data = $urandom();
               end
            end
         end
      end
   end

   function automatic logic [63:0] rule(input logic [31:0] ip, input logic [15:0] port,
                                        input logic [7:0] proto, input bit valid, input bit deny);
      return {ip, port, proto, valid, deny, 6'd0};
   endfunction

   // First-match scan over the table as written in mem
   task automatic model(input logic [55:0] key);
      logic [63:0] w;
      exp_hit = 0; exp_deny = 1; exp_err = 0; exp_idx = 0; exp_reads = 0;
      for (int i = 0; i < NUM_RULES; i++) begin
         w = mem[i];
         exp_reads = i + 1; exp_idx = i;
         if (w == PAR) begin exp_err = 1; return; end
         if (!w[7]) return;
         if ((w[63:32] == 0 || w[63:32] == key[55:24]) && (w[31:16] == 0 || w[31:16] == key[23:8]) &&
             (w[15:8] == 0 || w[15:8] == key[7:0])) begin
            exp_hit = 1; exp_deny = w[6]; return;
         end
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = '0;
   endtask

   task automatic do_lookup(input logic [55:0] key, input int nack, input bit drop, input bit par);
      int start, r0, q0;
      model(key);
      if (drop || par) begin exp_hit = 0; exp_deny = 1; exp_err = 1; exp_reads = 1; end
      exp_lat = drop ? (2 + VLD_TIMEOUT + 2 * nack) : (1 + 6 * exp_reads + 2 * nack);
      if (exp_err) t_errs++; else if (exp_hit) t_hits++; else t_misses++;
      nack_left = nack; drop_vld = drop; force_par = par;
      start = n_results; r0 = n_reads; q0 = n_req;
      @(posedge clk); #1 bus.lookup_key = key; bus.lookup_req = 1;
      acc = -1;
      for (int i = 0; i < 50 && acc < 0; i++) begin
         @(negedge clk);
         if (bus.lookup_rdy === 1'b1) acc = cyc;
      end
      @(posedge clk); #1 bus.lookup_req = 0;
      got = 0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         if (n_results != start) got = 1;
      end
      @(negedge clk);
      lat = res_cyc - acc; dreads = n_reads - r0; dreq = n_req - q0;
      drop_vld = 0; force_par = 0;
   endtask

   task automatic test_reset();
      reset = 1; bus.lookup_req = 0; bus.lookup_key = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++; if (bus.lookup_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy: got %b expected 0", bus.lookup_rdy); end
      vectors++; if ({bus.result_vld, bus.result_hit, bus.result_deny, bus.result_err, bus.rd_0_req} !== 5'b0) begin
         miscompares++; $display("FAIL reset_flags: got %b expected 00000", {bus.result_vld, bus.result_hit, bus.result_deny, bus.result_err, bus.rd_0_req}); end
      vectors++; if (bus.result_idx !== 8'd0 || bus.rd_0_addr !== 19'd0) begin
         miscompares++; $display("FAIL reset_idx_addr: got %0h/%0h expected 0/0", bus.result_idx, bus.rd_0_addr); end
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      vectors++; if (bus.lookup_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy_after: got %b expected 1", bus.lookup_rdy); end
   endtask

   task automatic test_rule0_hit();
      clear_mem();
      mem[0] = rule(32'h0A000001, 16'h0050, 8'h06, 1, 1);
      do_lookup({32'h0A000001, 16'h0050, 8'h06}, 0, 0, 0);
      vectors++; if (!got || lat !== 7) begin miscompares++; $display("FAIL rule0_latency: got %0d (seen %0d) expected 7", lat, got); end
      vectors++; if ({obs_hit, obs_deny, obs_err} !== 3'b110) begin miscompares++; $display("FAIL rule0_flags: got %b expected 110", {obs_hit, obs_deny, obs_err}); end
      vectors++; if (obs_idx !== 8'd0) begin miscompares++; $display("FAIL rule0_idx: got %0d expected 0", obs_idx); end
   endtask

   task automatic test_wildcard_rule3();
      clear_mem();
      mem[0] = rule(32'h0A000002, 16'h0050, 8'h06, 1, 1);
      mem[1] = rule(32'h0, 16'h0051, 8'h00, 1, 1);
      mem[2] = rule(32'h0, 16'h0, 8'h11, 1, 1);
      mem[3] = rule(32'h0, 16'h0, 8'h00, 1, 0);
      do_lookup({32'h0A000001, 16'h0050, 8'h06}, 0, 0, 0);
      vectors++; if (!got || lat !== 25) begin miscompares++; $display("FAIL wild3_latency: got %0d expected 25", lat); end
      vectors++; if ({obs_hit, obs_deny, obs_err} !== 3'b100) begin miscompares++; $display("FAIL wild3_flags: got %b expected 100", {obs_hit, obs_deny, obs_err}); end
      vectors++; if (obs_idx !== 8'd3) begin miscompares++; $display("FAIL wild3_idx: got %0d expected 3", obs_idx); end
   endtask

   task automatic test_end_of_table();
      clear_mem();
      mem[0] = rule(32'h0B000000, 16'h0, 8'h0, 1, 0);
      mem[1] = rule(32'h0C000000, 16'h0, 8'h0, 1, 0);
      mem[2] = rule(32'h0, 16'h0, 8'h0, 0, 0);
      mem[3] = rule(32'h0, 16'h0, 8'h0, 1, 0);
      do_lookup({32'h0A000001, 16'h0050, 8'h06}, 0, 0, 0);
      vectors++; if ({obs_hit, obs_deny, obs_err} !== 3'b010) begin miscompares++; $display("FAIL eot_flags: got %b expected 010", {obs_hit, obs_deny, obs_err}); end
      vectors++; if (dreads !== 3) begin miscompares++; $display("FAIL eot_reads: got %0d expected 3", dreads); end
      vectors++; if (!got || lat !== exp_lat) begin miscompares++; $display("FAIL eot_latency: got %0d expected %0d", lat, exp_lat); end
   endtask

   task automatic test_lost_arbitration();
      clear_mem();
      mem[0] = rule(32'h0A000001, 16'h0050, 8'h06, 1, 1);
      do_lookup({32'h0A000001, 16'h0050, 8'h06}, 3, 0, 0);
      vectors++; if (dreq !== 4) begin miscompares++; $display("FAIL nack_req_pulses: got %0d expected 4", dreq); end
      vectors++; if (dreads !== 1) begin miscompares++; $display("FAIL nack_reads: got %0d expected 1", dreads); end
      vectors++; if (!got || lat !== 13) begin miscompares++; $display("FAIL nack_latency: got %0d expected 13", lat); end
      vectors++; if ({obs_hit, obs_deny} !== 2'b11) begin miscompares++; $display("FAIL nack_flags: got %b expected 11", {obs_hit, obs_deny}); end
   endtask

   task automatic test_parity();
      clear_mem();
      mem[0] = rule(32'h0, 16'h0, 8'h0, 1, 0);
      do_lookup({32'h0A000001, 16'h0050, 8'h06}, 0, 0, 1);
      vectors++; if ({obs_hit, obs_deny, obs_err} !== 3'b011) begin miscompares++; $display("FAIL parity_flags: got %b expected 011", {obs_hit, obs_deny, obs_err}); end
      vectors++; if (!got || lat !== 7) begin miscompares++; $display("FAIL parity_latency: got %0d expected 7", lat); end
      repeat (5) @(negedge clk);
      vectors++; if ({bus.result_vld, bus.result_err, bus.result_deny} !== 3'b011) begin
         miscompares++; $display("FAIL parity_hold: got %b expected 011", {bus.result_vld, bus.result_err, bus.result_deny}); end
   endtask

   task automatic test_timeout();
      clear_mem();
      mem[0] = rule(32'h0A000001, 16'h0050, 8'h06, 1, 0);
      do_lookup({32'h0A000001, 16'h0050, 8'h06}, 0, 1, 0);
      vectors++; if (!got || lat !== 2 + VLD_TIMEOUT) begin miscompares++; $display("FAIL timeout_latency: got %0d expected %0d", lat, 2 + VLD_TIMEOUT); end
      vectors++; if ({obs_hit, obs_deny, obs_err} !== 3'b011) begin miscompares++; $display("FAIL timeout_flags: got %b expected 011", {obs_hit, obs_deny, obs_err}); end
   endtask

   task automatic test_reset_mid_scan();
      int start, q0;
      clear_mem();
      mem[0] = rule(32'h0, 16'h0, 8'h0, 1, 1);
      start = n_results;
      @(posedge clk); #1 bus.lookup_key = {32'h0A000001, 16'h0050, 8'h06}; bus.lookup_req = 1;
      @(negedge clk);
      @(posedge clk); #1 bus.lookup_req = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1;
      @(posedge clk); #1;
      @(posedge clk); #1 reset = 0;
      t_hits = 0; t_misses = 0; t_errs = 0;
      q0 = n_req;
      @(negedge clk);
      vectors++; if (bus.lookup_rdy !== 1'b1) begin miscompares++; $display("FAIL midreset_rdy: got %b expected 1", bus.lookup_rdy); end
      repeat (20) @(negedge clk);
      vectors++; if (n_results !== start) begin miscompares++; $display("FAIL midreset_result: got %0d results expected %0d", n_results, start); end
      vectors++; if (n_req !== q0) begin miscompares++; $display("FAIL midreset_req: got %0d requests expected 0", n_req - q0); end
   endtask

   task automatic test_full_miss();
      clear_mem();
      for (int i = 0; i < NUM_RULES; i++) mem[i] = rule(32'h0B000000 + i, 16'h0, 8'h0, 1, 0);
      mem[NUM_RULES] = rule(32'h0, 16'h0, 8'h0, 1, 0);
      do_lookup({32'h0A000001, 16'h0050, 8'h06}, 0, 0, 0);
      vectors++; if (!got || lat !== 1 + 6 * NUM_RULES) begin miscompares++; $display("FAIL full_latency: got %0d expected %0d", lat, 1 + 6 * NUM_RULES); end
      vectors++; if ({obs_hit, obs_deny, obs_err} !== 3'b010) begin miscompares++; $display("FAIL full_flags: got %b expected 010", {obs_hit, obs_deny, obs_err}); end
      vectors++; if (dreads !== NUM_RULES) begin miscompares++; $display("FAIL full_reads: got %0d expected %0d", dreads, NUM_RULES); end
   endtask

   task automatic test_random();
      logic [31:0] ips [3] = '{32'h0A000001, 32'h0A000002, 32'h0A000003};
      logic [15:0] ports [2] = '{16'h0050, 16'h01BB};
      logic [7:0]  protos [2] = '{8'h06, 8'h11};
      logic [55:0] key;
      int nack;
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < 256; i++) begin
            mem[i] = rule(($urandom_range(0, 2) == 0) ? 32'h0 : ips[$urandom_range(0, 2)],
                          ($urandom_range(0, 1) == 0) ? 16'h0 : ports[$urandom_range(0, 1)],
                          ($urandom_range(0, 1) == 0) ? 8'h0 : protos[$urandom_range(0, 1)],
                          $urandom_range(0, 15) != 0, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 39) == 0) mem[i] = PAR;
         end
         key  = {ips[$urandom_range(0, 2)], ports[$urandom_range(0, 1)], protos[$urandom_range(0, 1)]};
         nack = $urandom_range(0, 3);
         do_lookup(key, nack, 0, 0);
         vectors++; if (!got || lat !== exp_lat) begin miscompares++; $display("FAIL rand%0d_latency: got %0d expected %0d", n, lat, exp_lat); end
         vectors++; if ({obs_hit, obs_deny, obs_err} !== {exp_hit, exp_deny, exp_err}) begin
            miscompares++; $display("FAIL rand%0d_flags: got %b expected %b", n, {obs_hit, obs_deny, obs_err}, {exp_hit, exp_deny, exp_err}); end
         vectors++; if (exp_hit && obs_idx !== 8'(exp_idx)) begin miscompares++; $display("FAIL rand%0d_idx: got %0d expected %0d", n, obs_idx, exp_idx); end
         vectors++; if (dreads !== exp_reads) begin miscompares++; $display("FAIL rand%0d_reads: got %0d expected %0d", n, dreads, exp_reads); end
      end
   endtask

`ifdef FW_LOOKUP_STATS_EN
   task automatic test_stats();
      vectors++; if (bus.stat_hits !== 32'(t_hits)) begin miscompares++; $display("FAIL stat_hits: got %0d expected %0d", bus.stat_hits, t_hits); end
      vectors++; if (bus.stat_misses !== 32'(t_misses)) begin miscompares++; $display("FAIL stat_misses: got %0d expected %0d", bus.stat_misses, t_misses); end
      vectors++; if (bus.stat_errs !== 32'(t_errs)) begin miscompares++; $display("FAIL stat_errs: got %0d expected %0d", bus.stat_errs, t_errs); end
   endtask
`endif

   initial begin
      test_reset();
      test_rule0_hit();
      test_wildcard_rule3();
      test_end_of_table();
      test_lost_arbitration();
      test_parity();
      test_timeout();
      test_reset_mid_scan();
      test_full_miss();
      test_random();
`ifdef FW_LOOKUP_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
